// File: rtl/ysyx_23060077_fetch_ctrl_if.sv
// Fetch sequencer bus bundle: EXU redirect input, IFU request/response port,
// IDU instruction handoff and the flush pulse.
//   master : the fetch sequencer (drives the IFU request, the IDU offer and flush)
//   slave  : the surrounding core/testbench (drives redirect, IFU ready/response, IDU ready)
interface ysyx_23060077_fetch_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  // EXU control transfer
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  // IFU request/response
  logic                  ifu_req_valid;
  logic [DATA_WIDTH-1:0] ifu_req_pc;
  logic                  ifu_req_ready;
  logic                  ifu_rsp_valid;
  logic [31:0]           ifu_rsp_inst;
  // IDU handoff
  logic                  idu_valid;
  logic [DATA_WIDTH-1:0] idu_pc;
  logic [31:0]           idu_inst;
  logic                  idu_ready;
  // pipeline flush
  logic                  flush;

  modport master (
    input  redirect_valid, redirect_pc,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst,
    input  idu_ready,
    output ifu_req_valid, ifu_req_pc,
    output idu_valid, idu_pc, idu_inst,
    output flush
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst,
    output idu_ready,
    input  ifu_req_valid, ifu_req_pc,
    input  idu_valid, idu_pc, idu_inst,
    input  flush
  );
endinterface

// File: rtl/ysyx_23060077_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps a single IFU request outstanding,
// buffers the returned instruction for the IDU and applies EXU redirects,
// discarding any wrong-path fetch still in flight.
// Ports:
//   clock, reset : core clock, asynchronous active-high reset
//   bus          : master side of ysyx_23060077_fetch_ctrl_if
//                  (redirect in, IFU req/rsp, IDU offer, flush pulse out)
module ysyx_23060077_fetch_ctrl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h3000_0000)
) (
  input  logic                              clock,
  input  logic                              reset,
  ysyx_23060077_fetch_ctrl_if.master        bus
);

  localparam int unsigned INST_WIDTH = 32;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_KILL = 3'd4;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [2:0]            state_q,        state_d;
  logic [DATA_WIDTH-1:0] next_pc_q,      next_pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q,       req_pc_d;
  logic [INST_WIDTH-1:0] inst_q,         inst_d;
  logic                  kill_pending_q, kill_pending_d;
  logic                  req_valid_q,    req_valid_d;
  logic                  hold_q,         hold_d;
  logic                  flush_q,        flush_d;

  // State register and all datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      next_pc_q      <= RESET_PC;
      req_pc_q       <= RESET_PC;
      inst_q         <= '0;
      kill_pending_q <= 1'b0;
      req_valid_q    <= 1'b0;
      hold_q         <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      next_pc_q      <= next_pc_d;
      req_pc_q       <= req_pc_d;
      inst_q         <= inst_d;
      kill_pending_q <= kill_pending_d;
      req_valid_q    <= req_valid_d;
      hold_q         <= hold_d;
      flush_q        <= flush_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d        = state_q;
    next_pc_d      = next_pc_q;
    req_pc_d       = req_pc_q;
    inst_d         = inst_q;
    kill_pending_d = kill_pending_q;
    flush_d        = bus.redirect_valid;

    // Any redirect retargets the architectural PC; latest one wins.
    if (bus.redirect_valid) begin
      next_pc_d = bus.redirect_pc;
    end

    case (state_q)
      S_IDLE: begin
        state_d  = S_REQ;
        req_pc_d = bus.redirect_valid ? bus.redirect_pc : next_pc_q;
      end

      S_REQ: begin
        // req_pc must not move while the request is pending, so a redirect
        // here only marks the in-flight fetch as wrong-path.
        kill_pending_d = kill_pending_q | bus.redirect_valid;
        if (bus.ifu_req_ready) begin
          state_d = (kill_pending_q || bus.redirect_valid) ? S_KILL : S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.redirect_valid) begin
          if (bus.ifu_rsp_valid) begin
            // Wrong-path data lands this cycle: drop it, refetch at target.
            req_pc_d = bus.redirect_pc;
            state_d  = S_REQ;
          end else begin
            kill_pending_d = 1'b1;
            state_d        = S_KILL;
          end
        end else if (bus.ifu_rsp_valid) begin
          inst_d  = bus.ifu_rsp_inst;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.redirect_valid) begin
          req_pc_d = bus.redirect_pc;
          state_d  = S_REQ;
        end else if (bus.idu_ready) begin
          next_pc_d = req_pc_q + PC_STEP;
          req_pc_d  = req_pc_q + PC_STEP;
          state_d   = S_REQ;
        end
      end

      S_KILL: begin
        if (bus.ifu_rsp_valid) begin
          req_pc_d       = bus.redirect_valid ? bus.redirect_pc : next_pc_q;
          kill_pending_d = 1'b0;
          state_d        = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_valid_d = (state_d == S_REQ);
    hold_d      = (state_d == S_HOLD);
  end

  // The IDU offer is withdrawn in the same cycle a redirect resolves.
  assign bus.idu_valid     = hold_q & ~bus.redirect_valid;
  assign bus.idu_pc        = req_pc_q;
  assign bus.idu_inst      = inst_q;
  assign bus.ifu_req_valid = req_valid_q;
  assign bus.ifu_req_pc    = req_pc_q;
  assign bus.flush         = flush_q;

endmodule

// File: tb/tb_ysyx_23060077_fetch_ctrl.sv
// Scoreboard bench for ysyx_23060077_fetch_ctrl: expected request addresses and
// IDU deliveries are queued as each scenario is set up and consumed by a
// negedge monitor; a small IFU model answers every accepted request.
module tb_ysyx_23060077_fetch_ctrl;

  localparam int unsigned DW     = 32;
  localparam logic [31:0] RST_PC = 32'h3000_0000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_23060077_fetch_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  ysyx_23060077_fetch_ctrl #(.DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          rsp_delay = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_idu[$];
  logic [31:0] ifu_apc;
  logic [31:0] mon_e;
  logic        prev_redir;
  logic        prev_stall;
  logic [31:0] prev_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_hold();
    int i;
    i = 0;
    while (!bus.idu_valid && i < 40) begin
      tick();
      i++;
    end
    chk("hold_reached", 32'(bus.idu_valid), 32'd1);
  endtask

  // IFU model: one response per accepted request, rsp_delay extra cycles late
  initial begin
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_inst  = '0;
    forever begin
      @(negedge clock);
      if (!reset && bus.ifu_req_valid && bus.ifu_req_ready) begin
        ifu_apc = bus.ifu_req_pc;
        repeat (rsp_delay) @(posedge clock);
        @(posedge clock);
        #1;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_inst  = inst_of(ifu_apc);
        @(posedge clock);
        #1;
        bus.ifu_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops, flush timing, request stability under stall
  initial begin
    prev_redir = 1'b0;
    prev_stall = 1'b0;
    prev_pc    = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_redir = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("flush", 32'(bus.flush), 32'(prev_redir));
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.ifu_req_valid), 32'd1);
          chk("stall_pc", bus.ifu_req_pc, prev_pc);
        end
        if (bus.ifu_req_valid && bus.ifu_req_ready) begin
          if (exp_req.size() == 0) begin
            chk("req_unexpected", 32'(exp_req.size()), 32'd1);
          end else begin
            mon_e = exp_req.pop_front();
            chk("req_pc", bus.ifu_req_pc, mon_e);
          end
        end
        if (bus.idu_valid && bus.idu_ready) begin
          if (exp_idu.size() == 0) begin
            chk("idu_unexpected", 32'(exp_idu.size()), 32'd1);
          end else begin
            mon_e = exp_idu.pop_front();
            chk("idu_pc", bus.idu_pc, mon_e);
            chk("idu_inst", bus.idu_inst, inst_of(mon_e));
          end
        end
        prev_redir = bus.redirect_valid;
        prev_stall = bus.ifu_req_valid & ~bus.ifu_req_ready;
        prev_pc    = bus.ifu_req_pc;
      end
    end
  end

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.ifu_req_ready  = 1'b1;
    bus.idu_ready      = 1'b1;
    repeat (2) tick();

    // reset values
    chk("rst_req_valid", 32'(bus.ifu_req_valid), 32'd0);
    chk("rst_idu_valid", 32'(bus.idu_valid), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_idu_pc", bus.idu_pc, RST_PC);
    chk("rst_idu_inst", bus.idu_inst, 32'd0);
    chk("rst_req_pc", bus.ifu_req_pc, RST_PC);

    // sequential fetch, 3-cycle loop
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(RST_PC + 32'(4 * i));
      exp_idu.push_back(RST_PC + 32'(4 * i));
    end
    exp_req.push_back(RST_PC + 32'd12);
    reset = 1'b0;
    chk("idle_req_valid", 32'(bus.ifu_req_valid), 32'd0);
    tick();
    for (int k = 0; k < 9; k++) begin
      chk("seq_req_valid", 32'(bus.ifu_req_valid), 32'(k % 3 == 0));
      chk("seq_idu_valid", 32'(bus.idu_valid), 32'(k % 3 == 2));
      if (k % 3 == 2) chk("seq_idu_pc", bus.idu_pc, RST_PC + 32'(4 * (k / 3)));
      tick();
    end
    chk("seq_next_pc", bus.ifu_req_pc, RST_PC + 32'd12);

    // redirect in WAIT before the response returns
    bus.idu_ready = 1'b0;
    rsp_delay     = 1;
    exp_req.push_back(32'h8000_0010);
    exp_idu.push_back(32'h8000_0010);
    tick();
    chk("wait_idu_valid", 32'(bus.idu_valid), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0010;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wait_flush_hi", 32'(bus.flush), 32'd1);
    tick();
    chk("wait_flush_lo", 32'(bus.flush), 32'd0);
    chk("wait_redir_valid", 32'(bus.ifu_req_valid), 32'd1);
    chk("wait_redir_pc", bus.ifu_req_pc, 32'h8000_0010);
    rsp_delay     = 0;
    bus.idu_ready = 1'b1;
    wait_hold();
    bus.ifu_req_ready = 1'b0;
    tick();

    // redirect while the request is stalled
    chk("park_pc", bus.ifu_req_pc, 32'h8000_0014);
    bus.idu_ready = 1'b0;
    exp_req.push_back(32'h8000_0014);
    exp_req.push_back(32'h8000_0100);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    chk("stall_flush", 32'(bus.flush), 32'd1);
    chk("stall_pc_held", bus.ifu_req_pc, 32'h8000_0014);
    tick();
    chk("stall_pc_held2", bus.ifu_req_pc, 32'h8000_0014);
    tick();
    bus.ifu_req_ready = 1'b1;
    tick();
    chk("kill_idu_valid", 32'(bus.idu_valid), 32'd0);
    tick();
    chk("stall_redir_pc", bus.ifu_req_pc, 32'h8000_0100);
    chk("stall_redir_valid", 32'(bus.ifu_req_valid), 32'd1);

    // redirect in HOLD while the IDU is ready
    exp_req.push_back(32'h8000_0200);
    wait_hold();
    bus.idu_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    #1;
    chk("hold_gate", 32'(bus.idu_valid), 32'd0);
    rsp_delay = 2;
    tick();
    bus.redirect_valid = 1'b0;
    chk("hold_flush", 32'(bus.flush), 32'd1);
    chk("hold_redir_pc", bus.ifu_req_pc, 32'h8000_0200);

    // back-to-back redirects in WAIT/KILL: last one wins
    exp_req.push_back(32'h0000_0200);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    tick();
    chk("b2b_flush1", 32'(bus.flush), 32'd1);
    bus.redirect_pc = 32'h0000_0200;
    tick();
    chk("b2b_flush2", 32'(bus.flush), 32'd1);
    bus.redirect_valid = 1'b0;
    tick();
    chk("b2b_flush3", 32'(bus.flush), 32'd0);
    chk("b2b_pc", bus.ifu_req_pc, 32'h0000_0200);
    rsp_delay     = 0;
    bus.idu_ready = 1'b0;

    // PC wrap at the top of the address space
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    exp_idu.push_back(32'hFFFF_FFFC);
    wait_hold();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap_start_pc", bus.ifu_req_pc, 32'hFFFF_FFFC);
    bus.idu_ready = 1'b1;
    wait_hold();
    tick();
    chk("wrap_pc", bus.ifu_req_pc, 32'h0000_0000);
    bus.idu_ready = 1'b0;
    tick();

    // asynchronous reset while in WAIT with a response on the bus
    #1;
    reset = 1'b1;
    #1;
    chk("arst_req_valid", 32'(bus.ifu_req_valid), 32'd0);
    chk("arst_idu_valid", 32'(bus.idu_valid), 32'd0);
    chk("arst_flush", 32'(bus.flush), 32'd0);
    chk("arst_idu_pc", bus.idu_pc, RST_PC);
    chk("arst_idu_inst", bus.idu_inst, 32'd0);
    tick();
    exp_req.push_back(RST_PC);
    exp_idu.push_back(RST_PC);
    reset = 1'b0;
    chk("arst_idle_valid", 32'(bus.ifu_req_valid), 32'd0);
    bus.idu_ready = 1'b1;
    tick();
    chk("arst_refetch_valid", 32'(bus.ifu_req_valid), 32'd1);
    chk("arst_refetch_pc", bus.ifu_req_pc, RST_PC);
    wait_hold();
    bus.ifu_req_ready = 1'b0;
    repeat (3) tick();

    chk("req_q_drained", 32'(exp_req.size()), 32'd0);
    chk("idu_q_drained", 32'(exp_idu.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_fetch_ctrl.md
# ysyx_23060077_fetch_ctrl

Fetch sequencer for the ysyx_23060077 core. Owns the architectural fetch PC, issues one instruction-fetch request at a time to the IFU memory port, buffers the returned instruction for the IDU, and consumes the redirect target produced by the branch/CSR target mux, killing any wrong-path fetch in flight. It sits between the EXU redirect logic and the IFU/IDU handshakes; single outstanding request, no prediction.

## Interface
- DATA_WIDTH, 32, PC and target width
- RESET_PC, 32'h3000_0000, first fetch address after reset
- clock  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- redirect_valid  in  1  EXU resolved a control transfer (branch, jal/jalr, ecall, mret) this cycle
- redirect_pc  in  DATA_WIDTH  target from jump-target mux; valid with redirect_valid
- ifu_req_valid  out  1  fetch request valid
- ifu_req_pc  out  DATA_WIDTH  fetch address; stable while ifu_req_valid & ~ifu_req_ready
- ifu_req_ready  in  1  IFU accepts request this cycle
- ifu_rsp_valid  in  1  fetch data returned (one per accepted request)
- ifu_rsp_inst  in  32  returned instruction
- idu_valid  out  1  instruction available to IDU
- idu_pc  out  DATA_WIDTH  PC of offered instruction
- idu_inst  out  32  offered instruction
- idu_ready  in  1  IDU accepts
- flush  out  1  registered one-cycle pulse, asserted the cycle after a redirect is taken

## Operation
- Registers: state, next_pc, req_pc, inst_q, kill_pending.
- States: IDLE, REQ, WAIT, HOLD, KILL.
- IDLE: entered on reset; next cycle -> REQ with req_pc = next_pc = RESET_PC.
- REQ: ifu_req_valid=1, ifu_req_pc=req_pc. On ifu_req_ready -> WAIT (or KILL if kill_pending or redirect_valid this cycle).
- WAIT: on ifu_rsp_valid capture inst_q -> HOLD.
- HOLD: idu_valid = ~redirect_valid (combinational gate). On idu_valid & idu_ready: next_pc = req_pc + 4 (modulo 2^DATA_WIDTH, wraps), req_pc loaded with it -> REQ.
- KILL: wrong-path fetch outstanding; on ifu_rsp_valid discard data, req_pc <= next_pc, clear kill_pending -> REQ.
- Redirect handling (next_pc <= redirect_pc, flush pulses next cycle), by state:
  - IDLE: next_pc overwritten; first fetch uses redirect_pc.
  - REQ, not accepted: req_pc unchanged (address stability), set kill_pending; stay REQ.
  - REQ, accepted same cycle: -> KILL.
  - WAIT: -> KILL; response arriving same cycle is discarded, go straight to REQ at redirect_pc.
  - HOLD: inst_q dropped, no IDU transfer (idu_valid gated low), req_pc <= redirect_pc -> REQ.
  - KILL: next_pc overwritten (latest redirect wins); stay KILL unless rsp arrives same cycle, then REQ at redirect_pc.
- Back-to-back redirects: last one wins; flush pulses once per redirect cycle.
- ifu_rsp_valid outside WAIT/KILL is ignored.
- Low bits of redirect_pc passed unchanged; alignment checks are EXU's job.

## Timing
- Reset values: state=IDLE, next_pc=req_pc=RESET_PC, inst_q=0, kill_pending=0; ifu_req_valid=0, idu_valid=0, flush=0, idu_pc=RESET_PC, idu_inst=0.
- First ifu_req_valid: 1 cycle after reset deasserts (IDLE -> REQ).
- Minimum fetch-to-decode: request accepted cycle t, response t+1, idu_valid at t+2.
- Minimum loop: IDU accepts cycle t, next request valid t+1.
- Redirect to new request: from HOLD, 1 cycle; from WAIT/KILL, 1 cycle after the killed response.
- flush: registered; high exactly the cycle after each redirect_valid cycle.
- Reset asserted mid-operation: immediate return to IDLE, outstanding response afterwards ignored (state IDLE).

## Test plan
- Reset release, IFU ready always, 1-cycle response, IDU always ready -> requests at 0x30000000, 0x30000004, 0x30000008 every 3 cycles; idu_pc matches.
- Redirect to 0x80000010 while in WAIT -> response for old PC never reaches IDU; next request 0x80000010; flush one cycle.
- Redirect to 0x80000100 while REQ stalled (ifu_req_ready=0 for 3 cycles) -> ifu_req_pc held at old PC until accepted, its response discarded, next request 0x80000100.
- Redirect in HOLD with idu_ready=1 same cycle -> idu_valid low that cycle, no transfer, next request at target.
- Two redirects consecutive cycles (0x100 then 0x200) during WAIT -> only 0x200 fetched; flush high two cycles.
- PC 0xFFFFFFFC sequential -> next request 0x00000000; reset asserted in WAIT -> outputs to reset values same cycle, refetch RESET_PC.
